mem_self_test: RTL and testbench



---
 rtl/gm64_pkg.sv | 27 ++
 rtl/mem_self_test_sync_2ff.sv | 27 ++
 rtl/mem_self_test.sv | 256 +++++++++++++++++++++++++
 tb/tb_mem_self_test.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gm64_pkg.sv
// Shared GM64 definitions: debug palette colours, self-test pattern modes and
// the VIC debug input word.
package gm64_pkg;

    typedef enum logic [3:0] {
        COLOR_BLACK  = 4'd0,
        COLOR_RED    = 4'd1,
        COLOR_GREEN  = 4'd2,
        COLOR_YELLOW = 4'd3,
        COLOR_BLUE   = 4'd5,
        COLOR_GRAY   = 4'd6
    } color_e;

    typedef enum logic [1:0] {
        MODE_FIXED = 2'd0,
        MODE_ADDR  = 2'd1,
        MODE_WALK1 = 2'd2,
        MODE_NADDR = 2'd3
    } test_mode_e;

    // Word the VIC debug input takes: the palette colour plus a show strobe.
    typedef struct packed {
        logic   show;
        color_e color;
    } vic_debug_t;

endpackage

// File: rtl/mem_self_test_sync_2ff.sv
// Two-flop synchroniser bringing memory-controller handshake flags into the
// CPU phase clock domain.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clkPhi0,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clkPhi0 or negedge reset) begin
        if (!reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/mem_self_test.sv
// PSRAM self-test sequencer: write pass fills the bank/address range with a
// pattern, read pass verifies it, results shown as counts and a palette colour.
module mem_self_test
    import gm64_pkg::*;
#(
    parameter int                ADDR_W       = 16,
    parameter int                BANK_W       = 7,
    parameter int                DATA_W       = 8,
    parameter logic [ADDR_W-1:0] START_ADDR   = 16'hC000,
    parameter int                LENGTH       = 256,
    parameter int                NUM_BANKS    = 1,
    parameter int                TIMEOUT      = 1023,
    parameter int                STOP_ON_FAIL = 0
) (
    input  logic              clkPhi0,
    input  logic              reset,
    input  logic              i_start,
    input  logic [1:0]        i_mode,
    input  logic [DATA_W-1:0] i_pattern,
    output logic              o_ce,
    output logic              o_write,
    output logic [BANK_W-1:0] o_bank,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_wdata,
    input  logic              i_busy,
    input  logic              i_dataReady,
    input  logic [DATA_W-1:0] i_rdata,
    output logic              o_running,
    output logic              o_done,
    output logic              o_pass,
    output logic              o_timeout,
    output logic [15:0]       o_errCount,
    output logic [BANK_W-1:0] o_failBank,
    output logic [ADDR_W-1:0] o_failAddr,
    output logic [DATA_W-1:0] o_failData,
    output logic [3:0]        o_color
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR_REQ  = 3'd1;
    localparam logic [2:0] WR_WAIT = 3'd2;
    localparam logic [2:0] RD_REQ  = 3'd3;
    localparam logic [2:0] RD_WAIT = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    localparam logic [ADDR_W-1:0] LAST_ADDR = START_ADDR + ADDR_W'(LENGTH - 1);
    localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);
    localparam int                CNT_W     = $clog2(TIMEOUT + 1) + 1;
    localparam logic [CNT_W-1:0]  TIMEOUT_CNT = CNT_W'(TIMEOUT);

    function automatic logic [DATA_W-1:0] pattern_of(input logic [1:0] mode,
                                                     input logic [DATA_W-1:0] fixed,
                                                     input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] p;
        case (test_mode_e'(mode))
            MODE_FIXED: p = fixed;
            MODE_ADDR:  p = a[DATA_W-1:0];
            MODE_WALK1: p = DATA_W'(1) << (a % ADDR_W'(DATA_W));
            default:    p = ~a[DATA_W-1:0];
        endcase
        return p;
    endfunction

    logic [2:0]        state_q, state_d;
    logic [BANK_W-1:0] bank_q, bank_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        mode_q, mode_d;
    logic [DATA_W-1:0] pattern_q, pattern_d;
    logic [15:0]       err_q, err_d;
    logic [BANK_W-1:0] fail_bank_q, fail_bank_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0] fail_data_q, fail_data_d;
    logic              ce_q, ce_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              timeout_q, timeout_d;

    logic              busy_s, rdy_s;
    logic              active, last_loc, expired, mismatch;
    logic [DATA_W-1:0] expected;
    color_e            color;

    sync_2ff #(.WIDTH(1)) u_busy_sync (
        .clkPhi0 (clkPhi0),
        .reset   (reset),
        .i_d     (i_busy),
        .o_q     (busy_s)
    );

    sync_2ff #(.WIDTH(1)) u_rdy_sync (
        .clkPhi0 (clkPhi0),
        .reset   (reset),
        .i_d     (i_dataReady),
        .o_q     (rdy_s)
    );

    always_comb begin
        state_d     = state_q;
        bank_d      = bank_q;
        addr_d      = addr_q;
        mode_d      = mode_q;
        pattern_d   = pattern_q;
        err_d       = err_q;
        fail_bank_d = fail_bank_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        done_d      = done_q;
        pass_d      = pass_q;
        timeout_d   = timeout_q;
        ce_d        = 1'b0;
        mismatch    = 1'b0;
        active      = (state_q != IDLE) && (state_q != DONE);
        last_loc    = (addr_q == LAST_ADDR) && (bank_q == LAST_BANK);
        expired     = (cnt_q == TIMEOUT_CNT);
        expected    = pattern_of(mode_q, pattern_q, addr_q);

        case (state_q)
            IDLE, DONE: begin
                if (i_start) begin
                    err_d       = '0;
                    fail_bank_d = '0;
                    fail_addr_d = '0;
                    fail_data_d = '0;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    timeout_d   = 1'b0;
                    mode_d      = i_mode;
                    pattern_d   = i_pattern;
                    bank_d      = '0;
                    addr_d      = START_ADDR;
                    state_d     = WR_REQ;
                end
            end
            WR_REQ, RD_REQ: begin
                // Acceptance only counts once our own request has been on the bus.
                if (ce_q && busy_s) begin
                    state_d = (state_q == WR_REQ) ? WR_WAIT : RD_WAIT;
                end else begin
                    ce_d = 1'b1;
                end
            end
            WR_WAIT: begin
                if (!busy_s) begin
                    state_d = WR_REQ;
                    if (last_loc) begin
                        state_d = RD_REQ;
                        bank_d  = '0;
                        addr_d  = START_ADDR;
                    end else if (addr_q == LAST_ADDR) begin
                        bank_d = bank_q + BANK_W'(1);
                        addr_d = START_ADDR;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            RD_WAIT: begin
                if (rdy_s) begin
                    mismatch = (i_rdata != expected);
                    if (mismatch) begin
                        if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
                        if (err_q == 16'd0) begin
                            fail_bank_d = bank_q;
                            fail_addr_d = addr_q;
                            fail_data_d = i_rdata;
                        end
                    end
                    state_d = RD_REQ;
                    if (last_loc || (STOP_ON_FAIL != 0 && mismatch)) begin
                        state_d = DONE;
                    end else if (addr_q == LAST_ADDR) begin
                        bank_d = bank_q + BANK_W'(1);
                        addr_d = START_ADDR;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A handshake that completes on the expiry cycle still moves on.
        if (active && (state_d == state_q) && expired) begin
            state_d   = DONE;
            timeout_d = 1'b1;
            ce_d      = 1'b0;
        end

        if ((state_d == DONE) && (state_q != DONE)) begin
            done_d = 1'b1;
            pass_d = (err_d == 16'd0) && !timeout_d;
        end

        cnt_d = (state_d != state_q || !active) ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clkPhi0 or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            bank_q      <= '0;
            addr_q      <= '0;
            cnt_q       <= '0;
            mode_q      <= '0;
            pattern_q   <= '0;
            err_q       <= '0;
            fail_bank_q <= '0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            ce_q        <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bank_q      <= bank_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            pattern_q   <= pattern_d;
            err_q       <= err_d;
            fail_bank_q <= fail_bank_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
            ce_q        <= ce_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        case (state_q)
            WR_REQ, WR_WAIT: color = COLOR_YELLOW;
            RD_REQ, RD_WAIT: color = COLOR_BLUE;
            DONE:            color = timeout_q ? COLOR_GRAY : (pass_q ? COLOR_GREEN : COLOR_RED);
            default:         color = COLOR_BLACK;
        endcase
    end

    assign o_ce       = ce_q;
    assign o_write    = (state_q == WR_REQ) || (state_q == WR_WAIT);
    assign o_bank     = bank_q;
    assign o_addr     = addr_q;
    assign o_wdata    = o_write ? expected : '0;
    assign o_running  = active;
    assign o_done     = done_q;
    assign o_pass     = pass_q;
    assign o_timeout  = timeout_q;
    assign o_errCount = err_q;
    assign o_failBank = fail_bank_q;
    assign o_failAddr = fail_addr_q;
    assign o_failData = fail_data_q;
    assign o_color    = color;

endmodule

// File: tb/tb_mem_self_test.sv
// Directed bench: four differently parametrised sequencers share one memory
// model; the model serves whichever instance is selected.
module tb_mem_self_test;

    localparam logic [15:0] P_START [4] = '{16'hC000, 16'hC000, 16'hFFFE, 16'hC000};
    localparam int          P_LEN   [4] = '{4, 16, 4, 4};
    localparam int          P_BANKS [4] = '{1, 1, 2, 1};
    localparam int          P_STOP  [4] = '{0, 0, 0, 1};

    typedef struct {
        logic        wr;
        logic [6:0]  bank;
        logic [15:0] addr;
        logic [7:0]  data;
    } txn_t;

    logic        clk;
    logic        rst_n;
    logic        start [4];
    logic [1:0]  mode;
    logic [7:0]  pattern;
    logic        busy, rdy;
    logic [7:0]  rdata;

    logic        ce [4];
    logic        wr [4];
    logic [6:0]  bk [4];
    logic [15:0] ad [4];
    logic [7:0]  wd [4];
    logic        run [4];
    logic        done [4];
    logic        pass [4];
    logic        tmo [4];
    logic [15:0] errc [4];
    logic [6:0]  fbank [4];
    logic [15:0] faddr [4];
    logic [7:0]  fdata [4];
    logic [3:0]  color [4];

    int          sel;
    logic        no_busy, bad_en, corrupt_all;
    logic [15:0] bad_addr;
    logic [7:0]  mem [2][65536];
    txn_t        log_q [$];
    txn_t        cur;
    int          mcnt;

    int          checks = 0;
    int          errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dut
            mem_self_test #(
                .ADDR_W(16), .BANK_W(7), .DATA_W(8),
                .START_ADDR(P_START[gi]), .LENGTH(P_LEN[gi]), .NUM_BANKS(P_BANKS[gi]),
                .TIMEOUT(15), .STOP_ON_FAIL(P_STOP[gi])
            ) u_dut (
                .clkPhi0(clk), .reset(rst_n), .i_start(start[gi]), .i_mode(mode),
                .i_pattern(pattern), .o_ce(ce[gi]), .o_write(wr[gi]), .o_bank(bk[gi]),
                .o_addr(ad[gi]), .o_wdata(wd[gi]), .i_busy(busy), .i_dataReady(rdy),
                .i_rdata(rdata), .o_running(run[gi]), .o_done(done[gi]), .o_pass(pass[gi]),
                .o_timeout(tmo[gi]), .o_errCount(errc[gi]), .o_failBank(fbank[gi]),
                .o_failAddr(faddr[gi]), .o_failData(fdata[gi]), .o_color(color[gi])
            );
        end
    endgenerate

    // Controller model: busy for 4 cycles per request, read data strobed as busy drops.
    initial begin
        busy = 1'b0; rdy = 1'b0; rdata = 8'h00; mcnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy = 1'b0; rdy = 1'b0; mcnt = 0;
            end else begin
                rdy = 1'b0;
                if (mcnt != 0) begin
                    mcnt--;
                    if (mcnt == 0) begin
                        busy = 1'b0;
                        if (!cur.wr) begin
                            rdata = mem[cur.bank[0]][cur.addr];
                            rdy   = 1'b1;
                        end
                    end
                end else if (ce[sel] && !no_busy) begin
                    cur = '{wr[sel], bk[sel], ad[sel], wd[sel]};
                    log_q.push_back(cur);
                    $display("txn dut%0d %s bank=%0d addr=%h data=%h", sel, cur.wr ? "WR" : "RD",
                             cur.bank, cur.addr, cur.data);
                    if (cur.wr) begin
                        if (corrupt_all)                        mem[cur.bank[0]][cur.addr] = cur.data ^ 8'hFF;
                        else if (bad_en && cur.addr == bad_addr) mem[cur.bank[0]][cur.addr] = 8'h00;
                        else                                     mem[cur.bank[0]][cur.addr] = cur.data;
                    end
                    busy = 1'b1;
                    mcnt = 4;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start(input int d);
        @(negedge clk);
        start[d] = 1'b1;
        @(posedge clk);
        #1;
        start[d] = 1'b0;
    endtask

    task automatic wait_done(input int d, input string tag);
        int cyc = 0;
        while (!done[d] && cyc < 3000) begin
            @(posedge clk); #1; cyc++;
        end
        check(tag, done[d], 1'b1);
    endtask

    task automatic wait_ce(input int d, input logic level, input string tag);
        int cyc = 0;
        while (ce[d] !== level && cyc < 200) begin
            @(posedge clk); #1; cyc++;
        end
        check(tag, ce[d], level);
    endtask

    initial begin
        int   cyc;
        int   n_rd;
        txn_t t;
        logic [15:0] ea;

        rst_n = 1'b0; mode = 2'd0; pattern = 8'h00; sel = 0;
        no_busy = 1'b0; bad_en = 1'b0; corrupt_all = 1'b0; bad_addr = 16'h0000;
        for (int i = 0; i < 4; i++) start[i] = 1'b0;
        #12;
        check("rst_ce", ce[0], 1'b0);
        check("rst_done", done[0], 1'b0);
        check("rst_color", color[0], 4'd0);
        check("rst_addr", ad[0], 16'h0000);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Fixed pattern, plus a start pulse mid-run that must be ignored.
        sel = 0; mode = 2'd0; pattern = 8'h14; log_q.delete();
        pulse_start(0);
        check("t1_color_wr", color[0], 4'd3);
        repeat (10) @(posedge clk);
        #1;
        mode = 2'd3;
        pulse_start(0);
        wait_done(0, "t1_done");
        mode = 2'd0;
        check("t1_pass", pass[0], 1'b1);
        check("t1_err", errc[0], 16'd0);
        check("t1_color", color[0], 4'd2);
        check("t1_ntxn", log_q.size(), 8);
        for (int i = 0; i < 8 && i < log_q.size(); i++) begin
            t = log_q[i];
            check("t1_wr", t.wr, (i < 4));
            check("t1_addr", t.addr, 16'hC000 + 16'(i % 4));
            if (i < 4) check("t1_wdata", t.data, 8'h14);
        end

        // Walking one with a corrupted location.
        sel = 1; mode = 2'd2; bad_en = 1'b1; bad_addr = 16'hC005; log_q.delete();
        pulse_start(1);
        wait_done(1, "t2_done");
        check("t2_err", errc[1], 16'd1);
        check("t2_faddr", faddr[1], 16'hC005);
        check("t2_fdata", fdata[1], 8'h00);
        check("t2_fbank", fbank[1], 7'd0);
        check("t2_pass", pass[1], 1'b0);
        check("t2_color", color[1], 4'd1);
        bad_en = 1'b0;

        // Address wrap across two banks.
        sel = 2; mode = 2'd1; log_q.delete();
        pulse_start(2);
        wait_done(2, "t3_done");
        check("t3_pass", pass[2], 1'b1);
        check("t3_color", color[2], 4'd2);
        check("t3_ntxn", log_q.size(), 16);
        for (int i = 0; i < 16 && i < log_q.size(); i++) begin
            t  = log_q[i];
            ea = 16'hFFFE + 16'(i % 4);
            check("t3_wr", t.wr, (i < 8));
            check("t3_bank", t.bank, 7'((i / 4) % 2));
            check("t3_addr", t.addr, ea);
            if (i < 8) check("t3_wdata", t.data, ea[7:0]);
        end

        // Controller never answers: timeout after 16 cycles in WR_REQ.
        sel = 0; mode = 2'd0; no_busy = 1'b1;
        pulse_start(0);
        cyc = 0;
        while (!done[0] && cyc < 100) begin
            @(posedge clk); #1; cyc++;
        end
        check("t4_cycles", cyc, 16);
        check("t4_timeout", tmo[0], 1'b1);
        check("t4_pass", pass[0], 1'b0);
        check("t4_ce", ce[0], 1'b0);
        check("t4_color", color[0], 4'd6);
        no_busy = 1'b0;

        // Stop on first failure.
        sel = 3; mode = 2'd3; corrupt_all = 1'b1; log_q.delete();
        pulse_start(3);
        wait_done(3, "t6_done");
        n_rd = 0;
        foreach (log_q[i]) if (!log_q[i].wr) n_rd++;
        check("t6_reads", n_rd, 1);
        check("t6_err", errc[3], 16'd1);
        check("t6_faddr", faddr[3], 16'hC000);
        check("t6_fdata", fdata[3], 8'h00);
        check("t6_color", color[3], 4'd1);
        corrupt_all = 1'b0;

        // Reset while waiting on read data after a mismatch was logged.
        sel = 1; mode = 2'd2; bad_en = 1'b1; bad_addr = 16'hC005;
        pulse_start(1);
        cyc = 0;
        while (errc[1] != 16'd1 && cyc < 3000) begin
            @(posedge clk); #1; cyc++;
        end
        check("t5_err_seen", errc[1], 16'd1);
        wait_ce(1, 1'b1, "t5_ce_hi");
        wait_ce(1, 1'b0, "t5_ce_lo");
        check("t5_in_read", run[1], 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_ce", ce[1], 1'b0);
        check("t5_err", errc[1], 16'd0);
        check("t5_faddr", faddr[1], 16'h0000);
        check("t5_running", run[1], 1'b0);
        check("t5_color", color[1], 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("t5_no_resume", run[1], 1'b0);
        check("t5_done", done[1], 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
